// File: rtl/ex_unit_pkg.sv
// Shared encodings for the execute stage: class codes, operation codes, bus widths, MDU states.
// No logic here apart from small pure decode helpers used by the ALU and the MDU.
// Keep these values aligned with the decoder that fills the ID/EX register.
package ex_unit_pkg;

    localparam int ALU_SEL_W  = 3;
    localparam int ALU_OP_W   = 8;
    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    // Result class codes
    localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP    = 3'b000;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC  = 3'b001;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT  = 3'b010;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_ARITH  = 3'b011;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_MULDIV = 3'b100;

    // Operation codes
    localparam logic [ALU_OP_W-1:0] EXE_AND_OP    = 8'h24;
    localparam logic [ALU_OP_W-1:0] EXE_OR_OP     = 8'h25;
    localparam logic [ALU_OP_W-1:0] EXE_XOR_OP    = 8'h26;
    localparam logic [ALU_OP_W-1:0] EXE_SLL_OP    = 8'h7C;
    localparam logic [ALU_OP_W-1:0] EXE_SRL_OP    = 8'h02;
    localparam logic [ALU_OP_W-1:0] EXE_SRA_OP    = 8'h03;
    localparam logic [ALU_OP_W-1:0] EXE_ADD_OP    = 8'h20;
    localparam logic [ALU_OP_W-1:0] EXE_SUB_OP    = 8'h22;
    localparam logic [ALU_OP_W-1:0] EXE_SLT_OP    = 8'h2A;
    localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP   = 8'h2B;
    localparam logic [ALU_OP_W-1:0] EXE_MUL_OP    = 8'h18;
    localparam logic [ALU_OP_W-1:0] EXE_MULH_OP   = 8'h19;
    localparam logic [ALU_OP_W-1:0] EXE_MULHSU_OP = 8'h1C;
    localparam logic [ALU_OP_W-1:0] EXE_MULHU_OP  = 8'h1D;
    localparam logic [ALU_OP_W-1:0] EXE_DIV_OP    = 8'h1A;
    localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP   = 8'h1B;
    localparam logic [ALU_OP_W-1:0] EXE_REM_OP    = 8'h1E;
    localparam logic [ALU_OP_W-1:0] EXE_REMU_OP   = 8'h1F;

    // Iterative engine states
    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_muldiv_op(input logic [ALU_OP_W-1:0] op);
        return (op == EXE_MUL_OP)  || (op == EXE_MULH_OP) || (op == EXE_MULHSU_OP) ||
               (op == EXE_MULHU_OP) || (op == EXE_DIV_OP) || (op == EXE_DIVU_OP)  ||
               (op == EXE_REM_OP)  || (op == EXE_REMU_OP);
    endfunction

    function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP) ||
               (op == EXE_REM_OP) || (op == EXE_REMU_OP);
    endfunction

    function automatic logic is_rem_op(input logic [ALU_OP_W-1:0] op);
        return (op == EXE_REM_OP) || (op == EXE_REMU_OP);
    endfunction

    // Operand 1 is interpreted as signed
    function automatic logic signed_a(input logic [ALU_OP_W-1:0] op);
        return (op == EXE_MULH_OP) || (op == EXE_MULHSU_OP) ||
               (op == EXE_DIV_OP)  || (op == EXE_REM_OP);
    endfunction

    // Operand 2 is interpreted as signed
    function automatic logic signed_b(input logic [ALU_OP_W-1:0] op);
        return (op == EXE_MULH_OP) || (op == EXE_DIV_OP) || (op == EXE_REM_OP);
    endfunction

endpackage

// File: rtl/ex_unit_mdu.sv
// Iterative multiply/divide engine: radix-2 shift-add multiply, restoring divide, on magnitudes.
// Latency: 1 entry cycle + 32 BUSY cycles, result in DONE; divide-by-zero/overflow skip BUSY.
// busy is asserted from the entry cycle until DONE; the caller holds its operands meanwhile.
module mdu
    import ex_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    mdu_state_t  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;       // multiply: {partial, multiplier}; divide: {remainder, quotient}
    logic [31:0] dvs_q, dvs_d;       // multiplicand or divisor magnitude
    logic [7:0]  op_q, op_d;
    logic        neg_q, neg_d;       // product / quotient sign
    logic        negr_q, negr_d;     // remainder sign (follows dividend)
    logic        spec_q, spec_d;     // short-path result (div by zero, signed overflow)
    logic [31:0] spec_res_q, spec_res_d;

    logic        sa, sb;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [33:0] div_diff;
    logic [63:0] prod;
    logic [31:0] quo, rem;

    assign sa    = signed_a(op) && opa[31];
    assign sb    = signed_b(op) && opb[31];
    assign mag_a = sa ? (~opa + 32'd1) : opa;
    assign mag_b = sb ? (~opb + 32'd1) : opb;

    // One radix-2 step of each algorithm, selected by the latched op
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
    assign rem_sh   = acc_q[63:31];
    assign div_diff = {1'b0, rem_sh} - {2'b00, dvs_q};

    // Next-state and datapath update for the engine
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        dvs_d      = dvs_q;
        op_d       = op_q;
        neg_d      = neg_q;
        negr_d     = negr_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    op_d       = op;
                    neg_d      = sa ^ sb;
                    negr_d     = sa;
                    count_d    = 5'd0;
                    spec_d     = 1'b0;
                    spec_res_d = 32'd0;
                    state_d    = MDU_BUSY;
                    if (is_div_op(op)) begin
                        acc_d = {32'd0, mag_a};
                        dvs_d = mag_b;
                        if (opb == 32'd0) begin
                            spec_d     = 1'b1;
                            spec_res_d = is_rem_op(op) ? opa : 32'hFFFF_FFFF;
                            state_d    = MDU_DONE;
                        end else if (signed_b(op) && opa == 32'h8000_0000 && opb == 32'hFFFF_FFFF) begin
                            spec_d     = 1'b1;
                            spec_res_d = is_rem_op(op) ? 32'd0 : 32'h8000_0000;
                            state_d    = MDU_DONE;
                        end
                    end else begin
                        acc_d = {32'd0, mag_b};
                        dvs_d = mag_a;
                    end
                end
            end
            MDU_BUSY: begin
                if (is_div_op(op_q)) begin
                    if (!div_diff[33]) begin
                        acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                    end else begin
                        acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = MDU_DONE;
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
    end

    // Engine registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MDU_IDLE;
            count_q    <= 5'd0;
            acc_q      <= 64'd0;
            dvs_q      <= 32'd0;
            op_q       <= 8'd0;
            neg_q      <= 1'b0;
            negr_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            dvs_q      <= dvs_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            negr_q     <= negr_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
        end
    end

    assign prod = neg_q  ? (~acc_q + 64'd1) : acc_q;
    assign quo  = neg_q  ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem  = negr_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    // Sign correction and half/quotient/remainder selection in DONE
    always_comb begin
        result = 32'd0;
        if (spec_q) begin
            result = spec_res_q;
        end else begin
            case (op_q)
                EXE_MUL_OP:                              result = prod[31:0];
                EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP: result = prod[63:32];
                EXE_DIV_OP, EXE_DIVU_OP:                 result = quo;
                EXE_REM_OP, EXE_REMU_OP:                 result = rem;
                default:                                 result = 32'd0;
            endcase
        end
    end

    assign busy = !rst && ((state_q == MDU_IDLE && start) || state_q == MDU_BUSY);
    assign done = !rst && (state_q == MDU_DONE);

endmodule

// File: rtl/ex_unit.sv
// Execute stage: single-cycle logic/shift/arith ALU plus the iterative MDU and the result mux.
// Latency: ALU results same cycle; MULDIV stalls 33 cycles (1 for div-by-zero/overflow).
// stallreq holds ID/EX and earlier stages; we_o stays low while stalled.
module ex_unit
    import ex_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ex_alusel,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_opv1,
    input  logic [31:0] ex_opv2,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_we,
    output logic [4:0]  wd_o,
    output logic        we_o,
    output logic [31:0] wdata_o,
    output logic        stallreq
);

    logic        md_valid;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_result;
    logic [4:0]  shamt;

    assign md_valid = (ex_alusel == EXE_RES_MULDIV) && is_muldiv_op(ex_aluop);
    assign shamt    = ex_opv2[4:0];

    mdu u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (md_valid),
        .op     (ex_aluop),
        .opa    (ex_opv1),
        .opb    (ex_opv2),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // Result mux and write enable; unknown class/op gives 0 with the write still passed through
    always_comb begin
        wdata_o = 32'd0;
        we_o    = ex_we;
        case (ex_alusel)
            EXE_RES_LOGIC: begin
                case (ex_aluop)
                    EXE_AND_OP: wdata_o = ex_opv1 & ex_opv2;
                    EXE_OR_OP:  wdata_o = ex_opv1 | ex_opv2;
                    EXE_XOR_OP: wdata_o = ex_opv1 ^ ex_opv2;
                    default:    wdata_o = 32'd0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (ex_aluop)
                    EXE_SLL_OP: wdata_o = ex_opv1 << shamt;
                    EXE_SRL_OP: wdata_o = ex_opv1 >> shamt;
                    EXE_SRA_OP: wdata_o = $unsigned($signed(ex_opv1) >>> shamt);
                    default:    wdata_o = 32'd0;
                endcase
            end
            EXE_RES_ARITH: begin
                case (ex_aluop)
                    EXE_ADD_OP:  wdata_o = ex_opv1 + ex_opv2;
                    EXE_SUB_OP:  wdata_o = ex_opv1 - ex_opv2;
                    EXE_SLT_OP:  wdata_o = {31'd0, $signed(ex_opv1) < $signed(ex_opv2)};
                    EXE_SLTU_OP: wdata_o = {31'd0, ex_opv1 < ex_opv2};
                    default:     wdata_o = 32'd0;
                endcase
            end
            EXE_RES_MULDIV: begin
                if (md_done) begin
                    wdata_o = md_result;
                end else if (md_valid) begin
                    we_o = 1'b0;
                end
            end
            default: begin
                wdata_o = 32'd0;
            end
        endcase
        if (rst) begin
            wdata_o = 32'd0;
            we_o    = 1'b0;
        end
    end

    assign wd_o     = ex_waddr;
    assign stallreq = md_busy && !rst;

endmodule

// File: tb/tb_ex_unit.sv
// Directed bench for ex_unit: ALU results, MULDIV stall lengths and results, special divides, reset abort.
module tb_ex_unit;
    import ex_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  ex_alusel;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_opv1;
    logic [31:0] ex_opv2;
    logic [4:0]  ex_waddr;
    logic        ex_we;
    logic [4:0]  wd_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic        stallreq;

    int total = 0;
    int bad   = 0;

    ex_unit dut (
        .clk       (clk),
        .rst       (rst),
        .ex_alusel (ex_alusel),
        .ex_aluop  (ex_aluop),
        .ex_opv1   (ex_opv1),
        .ex_opv2   (ex_opv2),
        .ex_waddr  (ex_waddr),
        .ex_we     (ex_we),
        .wd_o      (wd_o),
        .we_o      (we_o),
        .wdata_o   (wdata_o),
        .stallreq  (stallreq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic we);
        ex_alusel = sel;
        ex_aluop  = op;
        ex_opv1   = a;
        ex_opv2   = b;
        ex_waddr  = wa;
        ex_we     = we;
    endtask

    // Single-cycle op: called just after a rising edge, returns just after the next one
    task automatic alu(input string tag, input logic [2:0] sel, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        drive(sel, op, a, b, 5'd7, 1'b1);
        @(negedge clk);
        chk(tag, wdata_o, exp);
        chk({tag, "_stall"}, {31'd0, stallreq}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // MULDIV op: counts stall cycles (bounded), then checks the DONE-cycle outputs
    task automatic md(input string tag, input logic [7:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
        int n;
        n = 0;
        drive(EXE_RES_MULDIV, op, a, b, 5'd9, 1'b1);
        @(negedge clk);
        chk({tag, "_we_stalled"}, {31'd0, we_o}, 32'd0);
        while (stallreq === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_stalls"}, n, exp_stall);
        chk(tag, wdata_o, exp);
        chk({tag, "_we"}, {31'd0, we_o}, 32'd1);
        chk({tag, "_wd"}, {27'd0, wd_o}, 32'd9);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(EXE_RES_MULDIV, EXE_MULHU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stallreq}, 32'd0);
        chk("rst_we", {31'd0, we_o}, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ADD wrap, same-cycle result with destination passthrough
        drive(EXE_RES_ARITH, EXE_ADD_OP, 32'h7FFF_FFFF, 32'h0000_0001, 5'd5, 1'b1);
        @(negedge clk);
        chk("add_wdata", wdata_o, 32'h8000_0000);
        chk("add_wd", {27'd0, wd_o}, 32'd5);
        chk("add_we", {31'd0, we_o}, 32'd1);
        chk("add_stall", {31'd0, stallreq}, 32'd0);
        @(posedge clk);
        #1;

        alu("sub",  EXE_RES_ARITH, EXE_SUB_OP,  32'd5, 32'd7, 32'hFFFF_FFFE);
        alu("and",  EXE_RES_LOGIC, EXE_AND_OP,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        alu("or",   EXE_RES_LOGIC, EXE_OR_OP,   32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34);
        alu("xor",  EXE_RES_LOGIC, EXE_XOR_OP,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34);
        alu("sll",  EXE_RES_SHIFT, EXE_SLL_OP,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002);
        alu("srl",  EXE_RES_SHIFT, EXE_SRL_OP,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
        alu("sra",  EXE_RES_SHIFT, EXE_SRA_OP,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
        alu("sltu", EXE_RES_ARITH, EXE_SLTU_OP, 32'h0000_0001, 32'hFFFF_FFFF, 32'd1);
        alu("slt",  EXE_RES_ARITH, EXE_SLT_OP,  32'h0000_0001, 32'hFFFF_FFFF, 32'd0);

        // Unknown class and unknown op within a class
        drive(3'b111, 8'h00, 32'h1234_5678, 32'h1, 5'd4, 1'b1);
        @(negedge clk);
        chk("unk_sel_wdata", wdata_o, 32'd0);
        chk("unk_sel_we", {31'd0, we_o}, 32'd1);
        @(posedge clk);
        #1;
        drive(EXE_RES_MULDIV, 8'hEE, 32'h1234_5678, 32'h1, 5'd4, 1'b0);
        @(negedge clk);
        chk("unk_op_wdata", wdata_o, 32'd0);
        chk("unk_op_we", {31'd0, we_o}, 32'd0);
        chk("unk_op_stall", {31'd0, stallreq}, 32'd0);
        @(posedge clk);
        #1;

        // Multiplies: 33 stall cycles each
        md("mulhu",  EXE_MULHU_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        md("mul",    EXE_MUL_OP,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        md("mulh",   EXE_MULH_OP,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        md("mulhsu", EXE_MULHSU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

        // Short-path divides: one stall cycle
        md("div0",   EXE_DIV_OP, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        md("rem0",   EXE_REM_OP, 32'd7, 32'd0, 32'd7, 1);
        md("divovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        md("removf", EXE_REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Signed divide, then back-to-back unsigned ops straight after DONE
        md("div_neg", EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        md("rem_neg", EXE_REM_OP,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        md("divu",    EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 33);
        md("remu",    EXE_REMU_OP, 32'd100, 32'd7, 32'd2, 33);

        // Reset while BUSY at count=10 abandons the op
        drive(EXE_RES_MULDIV, EXE_MULHU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1);
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("busy10_stall", {31'd0, stallreq}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_stall", {31'd0, stallreq}, 32'd0);
        chk("abort_we", {31'd0, we_o}, 32'd0);
        rst = 1'b0;
        drive(EXE_RES_ARITH, EXE_ADD_OP, 32'd2, 32'd3, 5'd3, 1'b1);
        @(negedge clk);
        chk("post_rst_add", wdata_o, 32'd5);
        chk("post_rst_stall", {31'd0, stallreq}, 32'd0);
        chk("post_rst_we", {31'd0, we_o}, 32'd1);
        @(posedge clk);
        #1;

        md("mul_after_rst", EXE_MUL_OP, 32'd3, 32'd5, 32'd15, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
